// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer and its register files.
package core_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  localparam int unsigned RegCount = 32;
  localparam int unsigned RegIdxW  = 5;
  localparam int unsigned NumSlots = 3;

  // Instruction field slices handed straight to the executor.
  localparam int unsigned Const16Lsb = 0;
  localparam int unsigned Const16W   = 16;
  localparam int unsigned Shift5Lsb  = 6;
  localparam int unsigned Shift5W    = 5;
  localparam int unsigned Addr26Lsb  = 0;
  localparam int unsigned Addr26W    = 26;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: three combinational read ports, one write port, synchronous clear.
module reg_file
  import core_pkg::*;
#(
  parameter bit ZeroReg = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [RegIdxW-1:0]           waddr,
  input  logic [31:0]                  wdata,
  input  logic [NumSlots*RegIdxW-1:0]  raddr,
  output logic [NumSlots*32-1:0]       rdata
);

  logic [31:0] mem_q [RegCount];
  logic [31:0] mem_d [RegCount];

  always_comb begin
    mem_d = mem_q;
    if (we && !(ZeroReg && (waddr == '0))) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RegCount; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!(ZeroReg && (raddr[s*RegIdxW +: RegIdxW] == '0))) begin
        rdata[s*32 +: 32] = mem_q[raddr[s*RegIdxW +: RegIdxW]];
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning pc and both register files.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         inst_mem_addr,
  output logic                inst_mem_valid,
  input  logic                inst_mem_ready,
  input  logic [31:0]         inst_mem_data,
  output logic [31:0]         dec_inst,
  input  logic [5:0]          dec_inst_num,
  input  logic [14:0]         dec_gen_idx,
  input  logic [14:0]         dec_flt_idx,
  input  logic                dec_wb_gen,
  input  logic                dec_wb_flt,
  input  logic [4:0]          dec_wb_idx,
  output logic                exec_reset,
  output logic [31:0]         exec_pc,
  output logic [5:0]          exec_inst_num,
  output logic [15:0]         exec_const16,
  output logic [4:0]          exec_shift5,
  output logic [25:0]         exec_addr26,
  output logic [95:0]         exec_general_regs,
  output logic [95:0]         exec_float_regs,
  input  logic                exec_completed,
  input  logic                exec_halted,
  input  logic [31:0]         exec_reg_out,
  input  logic [31:0]         exec_pc_out,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic [5:0]          inst_num_q, inst_num_d;
  logic                wb_gen_q, wb_gen_d;
  logic                wb_flt_q, wb_flt_d;
  logic [4:0]          wb_idx_q, wb_idx_d;
  logic [95:0]         gen_ops_q, gen_ops_d;
  logic [95:0]         flt_ops_q, flt_ops_d;
  logic [31:0]         reg_out_q, reg_out_d;
  logic [31:0]         next_pc_q, next_pc_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [95:0] gen_rdata, flt_rdata;
  logic        gen_we, flt_we;

  assign gen_we = (state_q == StWb) && wb_gen_q && (wb_idx_q != '0);
  assign flt_we = (state_q == StWb) && wb_flt_q;

  reg_file #(.ZeroReg(1'b1)) u_gen_rf (
    .clk   (clk),
    .reset (reset),
    .we    (gen_we),
    .waddr (wb_idx_q),
    .wdata (reg_out_q),
    .raddr (dec_gen_idx),
    .rdata (gen_rdata)
  );

  reg_file #(.ZeroReg(1'b0)) u_flt_rf (
    .clk   (clk),
    .reset (reset),
    .we    (flt_we),
    .waddr (wb_idx_q),
    .wdata (reg_out_q),
    .raddr (dec_flt_idx),
    .rdata (flt_rdata)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_num_d = inst_num_q;
    wb_gen_d   = wb_gen_q;
    wb_flt_d   = wb_flt_q;
    wb_idx_d   = wb_idx_q;
    gen_ops_d  = gen_ops_q;
    flt_ops_d  = flt_ops_q;
    reg_out_d  = reg_out_q;
    next_pc_d  = next_pc_q;
    retired_d  = retired_q;
    unique case (state_q)
      StFetch: begin
        if (inst_mem_ready) begin
          inst_d  = inst_mem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        inst_num_d = dec_inst_num;
        wb_gen_d   = dec_wb_gen;
        wb_flt_d   = dec_wb_flt;
        wb_idx_d   = dec_wb_idx;
        gen_ops_d  = gen_rdata;
        flt_ops_d  = flt_rdata;
        state_d    = StExec;
      end
      StExec: begin
        if (exec_completed) begin
          if (exec_halted) begin
            state_d = StHalt;
          end else begin
            reg_out_d = exec_reg_out;
            next_pc_d = exec_pc_out;
            state_d   = StWb;
          end
        end
      end
      StWb: begin
        pc_d      = next_pc_q;
        retired_d = retired_q + RETIRE_W'(1);
        state_d   = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_num_q <= '0;
      wb_gen_q   <= 1'b0;
      wb_flt_q   <= 1'b0;
      wb_idx_q   <= '0;
      gen_ops_q  <= '0;
      flt_ops_q  <= '0;
      reg_out_q  <= '0;
      next_pc_q  <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_num_q <= inst_num_d;
      wb_gen_q   <= wb_gen_d;
      wb_flt_q   <= wb_flt_d;
      wb_idx_q   <= wb_idx_d;
      gen_ops_q  <= gen_ops_d;
      flt_ops_q  <= flt_ops_d;
      reg_out_q  <= reg_out_d;
      next_pc_q  <= next_pc_d;
      retired_q  <= retired_d;
    end
  end

  // Reset overrides the state-derived controls during the reset cycle itself.
  assign inst_mem_valid    = !reset && (state_q == StFetch);
  assign inst_mem_addr     = pc_q;
  assign exec_reset        = reset || (state_q != StExec);
  assign halted            = !reset && (state_q == StHalt);
  assign dec_inst          = inst_q;
  assign exec_pc           = pc_q;
  assign exec_inst_num     = inst_num_q;
  assign exec_const16      = inst_q[Const16Lsb +: Const16W];
  assign exec_shift5       = inst_q[Shift5Lsb +: Shift5W];
  assign exec_addr26       = inst_q[Addr26Lsb +: Addr26W];
  assign exec_general_regs = gen_ops_q;
  assign exec_float_regs   = flt_ops_q;
  assign retired           = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench: plays instruction memory, decoder and executor against an ISA-level model.
module tb_core_sequencer;

  localparam logic [31:0] ResetPc = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_valid;
  logic        inst_mem_ready = 1'b0;
  logic [31:0] inst_mem_data = '0;
  logic [31:0] dec_inst;
  logic [5:0]  dec_inst_num = '0;
  logic [14:0] dec_gen_idx = '0;
  logic [14:0] dec_flt_idx = '0;
  logic        dec_wb_gen = 1'b0;
  logic        dec_wb_flt = 1'b0;
  logic [4:0]  dec_wb_idx = '0;
  logic        exec_reset;
  logic [31:0] exec_pc;
  logic [5:0]  exec_inst_num;
  logic [15:0] exec_const16;
  logic [4:0]  exec_shift5;
  logic [25:0] exec_addr26;
  logic [95:0] exec_general_regs;
  logic [95:0] exec_float_regs;
  logic        exec_completed = 1'b0;
  logic        exec_halted = 1'b0;
  logic [31:0] exec_reg_out = '0;
  logic [31:0] exec_pc_out = '0;
  logic        halted;
  logic [31:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  // Architectural model
  logic [31:0] gen_m [32];
  logic [31:0] flt_m [32];
  logic [31:0] pc_m;
  logic [31:0] retired_m;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(ResetPc), .RETIRE_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_mem_addr     (inst_mem_addr),
    .inst_mem_valid    (inst_mem_valid),
    .inst_mem_ready    (inst_mem_ready),
    .inst_mem_data     (inst_mem_data),
    .dec_inst          (dec_inst),
    .dec_inst_num      (dec_inst_num),
    .dec_gen_idx       (dec_gen_idx),
    .dec_flt_idx       (dec_flt_idx),
    .dec_wb_gen        (dec_wb_gen),
    .dec_wb_flt        (dec_wb_flt),
    .dec_wb_idx        (dec_wb_idx),
    .exec_reset        (exec_reset),
    .exec_pc           (exec_pc),
    .exec_inst_num     (exec_inst_num),
    .exec_const16      (exec_const16),
    .exec_shift5       (exec_shift5),
    .exec_addr26       (exec_addr26),
    .exec_general_regs (exec_general_regs),
    .exec_float_regs   (exec_float_regs),
    .exec_completed    (exec_completed),
    .exec_halted       (exec_halted),
    .exec_reg_out      (exec_reg_out),
    .exec_pc_out       (exec_pc_out),
    .halted            (halted),
    .retired           (retired)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      gen_m[i] = '0;
      flt_m[i] = '0;
    end
    pc_m      = ResetPc;
    retired_m = '0;
  endtask

  // Checks the state just after reset release (FETCH at the reset pc).
  task automatic check_post_reset();
    n_chk++; if (inst_mem_valid !== 1'b1) begin n_fail++;
      $display("FAIL rst_valid got=%b exp=1", inst_mem_valid); end
    n_chk++; if (inst_mem_addr !== ResetPc) begin n_fail++;
      $display("FAIL rst_addr got=%h exp=%h", inst_mem_addr, ResetPc); end
    n_chk++; if (exec_reset !== 1'b1) begin n_fail++;
      $display("FAIL rst_exec_reset got=%b exp=1", exec_reset); end
    n_chk++; if (halted !== 1'b0) begin n_fail++;
      $display("FAIL rst_halted got=%b exp=0", halted); end
    n_chk++; if (retired !== 32'd0) begin n_fail++;
      $display("FAIL rst_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (inst_mem_valid !== 1'b0 || exec_reset !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL in_reset valid/exec_reset/halted got=%b%b%b exp=010",
                         inst_mem_valid, exec_reset, halted); end
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    check_post_reset();
  endtask

  // One instruction from FETCH through WB/HALT; optionally reset during EXEC.
  task automatic run_instr(input logic [31:0] word, input int fstall, input int estall,
                           input logic [14:0] gi, input logic [14:0] fi,
                           input logic wbg, input logic wbf, input logic [4:0] widx,
                           input logic [31:0] rout, input logic [31:0] pcout,
                           input logic halt, input logic rst_in_exec);
    logic [95:0] exp_g, exp_f;
    logic [5:0]  num;
    logic [4:0]  idx;
    num = 6'($urandom);
    n_chk++; if (inst_mem_valid !== 1'b1 || inst_mem_addr !== pc_m) begin n_fail++;
      $display("FAIL fetch_req valid=%b addr=%h exp addr=%h", inst_mem_valid, inst_mem_addr,
               pc_m); end
    for (int i = 0; i < fstall; i++) begin
      inst_mem_ready = 1'b0;
      inst_mem_data  = $urandom;
      @(negedge clk);
      n_chk++; if (inst_mem_valid !== 1'b1 || exec_reset !== 1'b1) begin n_fail++;
        $display("FAIL fetch_stall valid=%b exec_reset=%b exp 1/1", inst_mem_valid,
                 exec_reset); end
    end
    inst_mem_ready = 1'b1;
    inst_mem_data  = word;
    @(negedge clk);
    // DECODE: completion here must be ignored
    inst_mem_ready = 1'b0;
    n_chk++; if (dec_inst !== word || exec_reset !== 1'b1 || inst_mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL decode dec_inst=%h exec_reset=%b valid=%b exp %h/1/0",
                         dec_inst, exec_reset, inst_mem_valid, word); end
    dec_inst_num   = num;
    dec_gen_idx    = gi;
    dec_flt_idx    = fi;
    dec_wb_gen     = wbg;
    dec_wb_flt     = wbf;
    dec_wb_idx     = widx;
    exec_completed = 1'b1;
    exec_halted    = 1'($urandom);
    exec_reg_out   = $urandom;
    exec_pc_out    = $urandom;
    @(negedge clk);
    // EXEC: scramble decoder and memory to prove the latches hold
    exec_completed = 1'b0;
    dec_inst_num   = 6'($urandom);
    dec_gen_idx    = 15'($urandom);
    dec_flt_idx    = 15'($urandom);
    dec_wb_gen     = 1'($urandom);
    dec_wb_flt     = 1'($urandom);
    dec_wb_idx     = 5'($urandom);
    inst_mem_ready = 1'b1;
    inst_mem_data  = $urandom;
    for (int s = 0; s < 3; s++) begin
      idx = gi[s*5 +: 5];
      exp_g[s*32 +: 32] = (idx == 5'd0) ? 32'd0 : gen_m[idx];
      idx = fi[s*5 +: 5];
      exp_f[s*32 +: 32] = flt_m[idx];
    end
    n_chk++; if (exec_reset !== 1'b0) begin n_fail++;
      $display("FAIL exec_reset_low got=%b exp=0", exec_reset); end
    n_chk++; if (exec_pc !== pc_m || exec_inst_num !== num) begin n_fail++;
      $display("FAIL exec_pc_num got=%h/%h exp=%h/%h", exec_pc, exec_inst_num, pc_m, num); end
    n_chk++; if (exec_const16 !== word[15:0] || exec_shift5 !== word[10:6] ||
                 exec_addr26 !== word[25:0]) begin n_fail++;
      $display("FAIL exec_fields got=%h/%h/%h exp=%h/%h/%h", exec_const16, exec_shift5,
               exec_addr26, word[15:0], word[10:6], word[25:0]); end
    n_chk++; if (exec_general_regs !== exp_g) begin n_fail++;
      $display("FAIL gen_operands got=%h exp=%h", exec_general_regs, exp_g); end
    n_chk++; if (exec_float_regs !== exp_f) begin n_fail++;
      $display("FAIL flt_operands got=%h exp=%h", exec_float_regs, exp_f); end
    for (int i = 0; i < estall; i++) begin
      @(negedge clk);
      n_chk++; if (exec_reset !== 1'b0 || exec_general_regs !== exp_g ||
                   exec_float_regs !== exp_f || dec_inst !== word) begin n_fail++;
        $display("FAIL exec_hold exec_reset=%b dec_inst=%h exp 0/%h", exec_reset, dec_inst,
                 word); end
    end
    inst_mem_ready = 1'b0;
    if (rst_in_exec) begin
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      n_chk++; if (exec_reset !== 1'b1 || inst_mem_valid !== 1'b0 || halted !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset exec_reset/valid/halted got=%b%b%b exp=100",
                           exec_reset, inst_mem_valid, halted); end
      reset = 1'b0;
      @(negedge clk);
      check_post_reset();
      return;
    end
    exec_completed = 1'b1;
    exec_halted    = halt;
    exec_reg_out   = rout;
    exec_pc_out    = pcout;
    @(negedge clk);
    exec_completed = 1'b0;
    exec_halted    = 1'b0;
    exec_reg_out   = $urandom;
    exec_pc_out    = $urandom;
    if (halt) begin
      n_chk++; if (halted !== 1'b1 || inst_mem_valid !== 1'b0 || exec_reset !== 1'b1) begin
        n_fail++; $display("FAIL halt_entry halted/valid/exec_reset got=%b%b%b exp=101",
                           halted, inst_mem_valid, exec_reset); end
      return;
    end
    n_chk++; if (exec_reset !== 1'b1 || inst_mem_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL wb_cycle exec_reset/valid/halted got=%b%b%b exp=100",
                         exec_reset, inst_mem_valid, halted); end
    if (wbg && widx != 5'd0) gen_m[widx] = rout;
    if (wbf) flt_m[widx] = rout;
    pc_m = pcout;
    retired_m = retired_m + 32'd1;
    @(negedge clk);
    n_chk++; if (retired !== retired_m || inst_mem_addr !== pc_m || inst_mem_valid !== 1'b1)
      begin n_fail++; $display("FAIL retire retired=%0d addr=%h exp %0d/%h", retired,
                               inst_mem_addr, retired_m, pc_m); end
  endtask

  task automatic test_fetch_stall();
    run_instr(32'h2108_0005, 3, 0, 15'd0, 15'd0, 1'b0, 1'b0, 5'd0, 32'h0, pc_m + 32'd4,
              1'b0, 1'b0);
  endtask

  task automatic test_writeback();
    run_instr($urandom, 0, 1, 15'd0, 15'd0, 1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, pc_m + 32'd4,
              1'b0, 1'b0);
    run_instr($urandom, 0, 0, {5'd1, 5'd2, 5'd3}, 15'd0, 1'b0, 1'b0, 5'd0, 32'h0,
              pc_m + 32'd4, 1'b0, 1'b0);
  endtask

  task automatic test_zero_reg();
    run_instr($urandom, 1, 0, 15'd0, 15'd0, 1'b1, 1'b0, 5'd0, 32'h1234, pc_m + 32'd4,
              1'b0, 1'b0);
    run_instr($urandom, 0, 0, 15'd0, 15'd0, 1'b0, 1'b1, 5'd0, 32'h3F80_0000, pc_m + 32'd4,
              1'b0, 1'b0);
    run_instr($urandom, 0, 0, 15'd0, 15'd0, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA, pc_m + 32'd8,
              1'b0, 1'b0);
    run_instr($urandom, 0, 0, {5'd9, 5'd0, 5'd0}, {5'd9, 5'd0, 5'd0}, 1'b0, 1'b0, 5'd0,
              32'h0, pc_m + 32'd4, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b0, 1'b0);
    end
  endtask

  task automatic test_halt();
    run_instr($urandom, 0, 2, 15'd0, 15'd0, 1'b1, 1'b1, 5'd5, 32'hBAD0_BAD0, 32'hFFFF_0000,
              1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      inst_mem_ready = 1'b1;
      exec_completed = 1'($urandom);
      @(negedge clk);
      n_chk++; if (halted !== 1'b1 || inst_mem_valid !== 1'b0 || exec_reset !== 1'b1 ||
                   inst_mem_addr !== pc_m || retired !== retired_m) begin n_fail++;
        $display("FAIL halt_sticky halted=%b valid=%b addr=%h retired=%0d exp 1/0/%h/%0d",
                 halted, inst_mem_valid, inst_mem_addr, retired, pc_m, retired_m); end
    end
    inst_mem_ready = 1'b0;
    exec_completed = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    test_reset();
    run_instr($urandom, 0, 0, 15'd0, 15'd0, 1'b1, 1'b1, 5'd7, 32'h4049_0FDB, pc_m + 32'd4,
              1'b0, 1'b0);
    run_instr($urandom, 0, 1, {5'd0, 5'd0, 5'd7}, {5'd0, 5'd0, 5'd7}, 1'b0, 1'b0, 5'd0,
              32'h0, 32'h0, 1'b0, 1'b1);
    run_instr($urandom, 0, 0, {5'd0, 5'd0, 5'd7}, {5'd31, 5'd1, 5'd7}, 1'b0, 1'b0, 5'd0,
              32'h0, pc_m + 32'd4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_writeback();
    test_zero_reg();
    test_random();
    test_halt();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
